// File: rtl/pipelined_adder.sv
// Chunked ripple-carry adder/subtractor: each stage adds one CHUNK-bit slice and
// registers its carry for the next stage, with a valid/ready stall on the output.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // The pipeline advances as a whole only when the output slot is free or
   // being consumed; otherwise every register holds.
   logic             advance;
   logic [WIDTH-1:0] eff_b;
   logic             cin0;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];

   logic [STAGES-1:0] c_nxt;
   logic [WIDTH-1:0]  s_nxt [STAGES];

   assign out_valid = v_q[STAGES-1];
   assign in_ready  = !(out_valid && !out_ready);
   assign advance   = in_ready;

   assign eff_b = sub ? ~b : b;
   assign cin0  = sub ? 1'b1 : cin;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         logic [CHUNK:0] part;
         if (k == 0) begin : g_first
            assign part     = {1'b0, a[CHUNK-1:0]} + {1'b0, eff_b[CHUNK-1:0]}
                              + (CHUNK+1)'(cin0);
            assign s_nxt[0] = WIDTH'(part[CHUNK-1:0]);
         end else begin : g_rest
            assign part     = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
                              + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
                              + (CHUNK+1)'(c_q[k-1]);
            // Chunk k of the running sum is still zero here, so OR inserts it.
            assign s_nxt[k] = s_q[k-1] | (WIDTH'(part[CHUNK-1:0]) << (k*CHUNK));
         end
         assign c_nxt[k] = part[CHUNK];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            s_q[i] <= '0;
         end
      end else if (advance) begin
         v_q[0] <= in_valid;
         a_q[0] <= a;
         b_q[0] <= eff_b;
         s_q[0] <= s_nxt[0];
         c_q[0] <= c_nxt[0];
         for (int i = 1; i < STAGES; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
            s_q[i] <= s_nxt[i];
            c_q[i] <= c_nxt[i];
         end
      end
   end

   // Overflow: operand signs agree but the result sign differs.
   assign sum  = s_q[STAGES-1];
   assign cout = c_q[STAGES-1];
   assign ovf  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                 (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases, random streams with stalls
// and bubbles, and mid-flight reset, scored against an integer arithmetic model.
module tb_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [WIDTH+1:0] exp_q[$];
   int               pop_cyc[$];

   pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: plain integer arithmetic, packed as {cout, ovf, sum}.
   function automatic logic [WIDTH+1:0] model(input logic [15:0] x, y,
                                              input logic c, s);
      int ux, uy, sx, sy, ut, st;
      logic co, ov;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         ut = ux - uy;
         st = sx - sy;
         co = (ux >= uy);
      end else begin
         ut = ux + uy + int'(c);
         st = sx + sy + int'(c);
         co = (ut > 65535);
      end
      ov = (st > 32767) || (st < -32768);
      return {co, ov, ut[15:0]};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            logic [WIDTH+1:0] e;
            pop_cyc.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_unexpected got=%h required=none", {cout, ovf, sum});
            end else begin
               e = exp_q.pop_front();
               if ({cout, ovf, sum} !== e) begin
                  n_err++;
                  $display("FAIL scoreboard got=%h required=%h", {cout, ovf, sum}, e);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
   end

   task automatic send(input logic [15:0] ta, tb_v, input logic tc, ts);
      int t;
      a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout got=in_ready 0 required=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({out_valid, in_ready, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL reset_state got=%b required=%b",
                  {out_valid, in_ready, cout, ovf, sum}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_directed(input string name, input logic [15:0] ta, tb_v,
                                input logic tc, ts, input logic [15:0] es,
                                input logic ec, eo);
      send(ta, tb_v, tc, ts);
      for (int i = 0; i < STAGES - 1; i++) begin
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early got=out_valid %b required=0 at stage %0d", name, out_valid, i);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if ({out_valid, cout, ovf, sum} !== {1'b1, ec, eo, es}) begin
         n_err++;
         $display("FAIL %s got=v%b c%b o%b s%h required=v1 c%b o%b s%h",
                  name, out_valid, cout, ovf, sum, ec, eo, es);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int c0;
      pop_cyc.delete();
      c0 = cyc;
      for (int i = 0; i < 100; i++)
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      n_cmp++;
      if (cyc - c0 != 100) begin
         n_err++;
         $display("FAIL b2b_accept_cycles got=%0d required=100", cyc - c0);
      end
      drain();
      n_cmp++;
      if (pop_cyc.size() != 100) begin
         n_err++;
         $display("FAIL b2b_count got=%0d required=100", pop_cyc.size());
      end else begin
         n_cmp++;
         if (pop_cyc[99] - pop_cyc[0] != 99) begin
            n_err++;
            $display("FAIL b2b_rate got=%0d required=99", pop_cyc[99] - pop_cyc[0]);
         end
      end
   endtask

   task automatic test_stall();
      pop_cyc.delete();
      out_ready = 1'b0;
      for (int i = 0; i < STAGES; i++)
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({in_ready, out_valid} !== 2'b01 || {cout, ovf, sum} !== exp_q[0]) begin
            n_err++;
            $display("FAIL stall_hold got=r%b v%b %h required=r0 v1 %h",
                     in_ready, out_valid, {cout, ovf, sum}, exp_q[0]);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      n_cmp++;
      if (pop_cyc.size() != STAGES + 1) begin
         n_err++;
         $display("FAIL stall_count got=%0d required=%0d", pop_cyc.size(), STAGES + 1);
      end
   endtask

   task automatic test_random_stall();
      pop_cyc.delete();
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
         end
         begin
            repeat (250) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
      n_cmp++;
      if (pop_cyc.size() != 60) begin
         n_err++;
         $display("FAIL random_stall_count got=%0d required=60", pop_cyc.size());
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++)
         send(16'($urandom_range(1, 16'hFFFF)), 16'($urandom), 1'b1, 1'b0);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      n_cmp++;
      if ({out_valid, in_ready, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL mid_reset_clear got=%b required=%b",
                  {out_valid, in_ready, cout, ovf, sum}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
      end
      @(posedge clk); #1 rst = 1'b0;
      pop_cyc.delete();
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (pop_cyc.size() != 0) begin
         n_err++;
         $display("FAIL mid_reset_leak got=%0d results required=0", pop_cyc.size());
      end
      test_directed("post_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      test_directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      test_directed("sub_neg",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      test_directed("add_ripple", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      test_back_to_back();
      test_stall();
      test_random_stall();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
- REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-005 SHALL have port in_valid  input  1  operand set presented.
- REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
- REQ-007 SHALL have ports a, b  input  WIDTH each  unsigned/two's-complement operands.
- REQ-008 SHALL have port cin  input  1  carry-in for add mode.
- REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract.
- REQ-010 SHALL have port out_valid  output  1  result available.
- REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
- REQ-012 SHALL have port sum  output  WIDTH  result.
- REQ-013 SHALL have port cout  output  1  carry out of MSB (no-borrow flag in sub mode).
- REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
- REQ-015 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
- REQ-016 Add mode SHALL compute {cout,sum} = a + b + cin, full WIDTH+1-bit result.
- REQ-017 Sub mode SHALL compute a + ~b + 1; cin SHALL be ignored; cout=1 means a >= b unsigned.
- REQ-018 ovf SHALL be 1 iff operand sign bits (a, effective b) are equal and differ from sum MSB.
- REQ-019 Stage k (0..STAGES-1) SHALL add chunk k of a and effective b plus the carry registered from stage k-1 (stage 0 uses cin or 1 per mode); unconsumed upper chunks SHALL be carried forward in pipeline registers, completed lower chunks likewise.
- REQ-020 Latency SHALL be exactly STAGES cycles from accepting transfer to out_valid with no stall; throughput one result per cycle.
- REQ-021 Each stage SHALL carry a valid bit; bubbles (in_valid=0) SHALL propagate as invalid slots and never produce out_valid.
- REQ-022 Stall: when out_valid && !out_ready, the whole pipeline SHALL hold (all registers unchanged) and in_ready SHALL be 0.
- REQ-023 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
- REQ-024 Results SHALL emerge in acceptance order; none dropped or duplicated under any stall pattern.
- REQ-025 sum/cout/ovf SHALL hold stable while out_valid && !out_ready.
- REQ-026 Simultaneous out transfer and in transfer in the same cycle SHALL both complete.
- REQ-027 STAGES=1 SHALL degenerate to a single registered full-width adder with latency 1.

Reset
- REQ-028 rst=1 SHALL asynchronously clear all stage valid bits and data registers; out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- REQ-029 rst asserted mid-operation SHALL discard all in-flight results; first accepted transfer after rst deasserts SHALL appear after STAGES cycles.

Verification (WIDTH=16, CHUNK=4, out_ready=1 unless stated)
- REQ-030 a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- REQ-031 a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- REQ-032 a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1 (carry ripples through all 4 stages).
- REQ-033 100 back-to-back random transfers -> 100 results in order, one per cycle, matching reference model.
- REQ-034 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs frozen, no loss; release -> drain in order.
- REQ-035 rst pulsed with 3 operations in flight -> out_valid=0 immediately, none of the 3 emerges afterward.
